// File: rtl/spr_gamma_encode.sv
// Sequential re-gamma encoder: 5-step binary search over the shared de-gamma LUT.
// Define SPR_GAMMA_ROUND_EN to add the nearest-bound (ties up) rounding step.
module spr_gamma_encode (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [10:0] in_lin,
  output logic [4:0]  lut_idx,
  input  logic [10:0] lut_lobound,
  input  logic [10:0] lut_upbound,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_code
);

  localparam int unsigned IDX_W = 5;
  localparam int unsigned VAL_W = 11;
  localparam int unsigned BIT_W = 3;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(16);
`ifdef SPR_GAMMA_ROUND_EN
  localparam logic [IDX_W-1:0] IDX_MAX = '1;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
`ifdef SPR_GAMMA_ROUND_EN
    S_ROUND  = 2'd2,
`endif
    S_DONE   = 2'd3
  } state_t;

  state_t             state;
  logic [VAL_W-1:0]   v;
  logic [IDX_W-1:0]   code;
  logic [BIT_W-1:0]   b;

  logic               hit_c;
  logic [IDX_W-1:0]   code_nxt_c;
  logic [IDX_W-1:0]   probe_nxt_c;

  // lut_idx holds the current candidate during SEARCH, so the compare uses it directly.
  always_comb begin
    hit_c       = (lut_lobound <= v);
    code_nxt_c  = hit_c ? lut_idx : code;
    probe_nxt_c = code_nxt_c | (IDX_W'(1) << (b - BIT_W'(1)));
  end

`ifdef SPR_GAMMA_ROUND_EN
  logic [VAL_W-1:0] dlo_c;
  logic [VAL_W-1:0] dup_c;
  logic             round_up_c;

  // In ROUND lut_idx equals code; dup wraps at the top code but is masked there.
  always_comb begin
    dlo_c      = v - lut_lobound;
    dup_c      = lut_upbound - v;
    round_up_c = (code != IDX_MAX) && (dup_c <= dlo_c);
  end
`else
  // The upper bound only feeds the rounding step, which this build leaves out.
  logic unused_upbound;
  assign unused_upbound = ^lut_upbound;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_code  <= '0;
      lut_idx   <= '0;
      v         <= '0;
      code      <= '0;
      b         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            v        <= in_lin;
            code     <= '0;
            b        <= BIT_W'(4);
            lut_idx  <= IDX_TOP;
            in_ready <= 1'b0;
            state    <= S_SEARCH;
          end
        end

        S_SEARCH: begin
          code <= code_nxt_c;
          if (b == '0) begin
`ifdef SPR_GAMMA_ROUND_EN
            lut_idx <= code_nxt_c;
            state   <= S_ROUND;
`else
            lut_idx   <= '0;
            out_code  <= code_nxt_c;
            out_valid <= 1'b1;
            state     <= S_DONE;
`endif
          end else begin
            b       <= b - BIT_W'(1);
            lut_idx <= probe_nxt_c;
          end
        end

`ifdef SPR_GAMMA_ROUND_EN
        S_ROUND: begin
          code      <= round_up_c ? code + IDX_W'(1) : code;
          out_code  <= round_up_c ? code + IDX_W'(1) : code;
          lut_idx   <= '0;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
`endif

        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          lut_idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spr_gamma_encode.sv
// Directed bench for spr_gamma_encode with a behavioural de-gamma LUT.
// Expected codes follow SPR_GAMMA_ROUND_EN when the same define is passed to the bench.
module tb_spr_gamma_encode;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] in_lin;
  logic [4:0]  lut_idx;
  logic [10:0] lut_lobound;
  logic [10:0] lut_upbound;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_code;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef SPR_GAMMA_ROUND_EN
  localparam int LAT   = 6;
  localparam bit ROUND = 1'b1;
`else
  localparam int LAT   = 5;
  localparam bit ROUND = 1'b0;
`endif

  // Monotonic lower bounds; the upper bound of a code is the next code's lower bound.
  logic [10:0] lob_tab [32];
  initial begin
    lob_tab = '{11'd0,    11'd96,   11'd120,  11'd145,  11'd170,  11'd195,  11'd220,  11'd245,
                11'd270,  11'd300,  11'd326,  11'd352,  11'd364,  11'd400,  11'd440,  11'd500,
                11'd570,  11'd650,  11'd720,  11'd790,  11'd870,  11'd952,  11'd1084, 11'd1200,
                11'd1320, 11'd1440, 11'd1560, 11'd1680, 11'd1800, 11'd1900, 11'd1970, 11'd2038};
  end

  assign lut_lobound = lob_tab[lut_idx];
  assign lut_upbound = (lut_idx == 5'd31) ? 11'd2047 : lob_tab[lut_idx + 5'd1];

  spr_gamma_encode dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_lin      (in_lin),
    .lut_idx     (lut_idx),
    .lut_lobound (lut_lobound),
    .lut_upbound (lut_upbound),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_code    (out_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Full transaction from a negedge: accept, optional probe check, latency, hold, release.
  task automatic xact(input logic [10:0] val, input logic [4:0] exp_floor,
                      input logic [4:0] exp_round, input bit chk_probe,
                      input logic [24:0] probes, input int hold);
    logic [4:0] exp_code;
    exp_code  = ROUND ? exp_round : exp_floor;
    in_valid  = 1'b1;
    in_lin    = val;
    out_ready = (hold == 0);
    check("accept_ready", in_ready, 1'b1);
    for (int k = 0; k <= LAT; k++) begin
      @(negedge clk);
      if (k == 0) in_valid = 1'b0;
      if (chk_probe && k < 5) check($sformatf("probe%0d_%0d", k, val), lut_idx, probes[24 - 5*k -: 5]);
      if (k < LAT) begin
        check($sformatf("early_valid_%0d", val), out_valid, 1'b0);
        check($sformatf("busy_ready_%0d", val), in_ready, 1'b0);
      end else begin
        check($sformatf("out_valid_%0d", val), out_valid, 1'b1);
        check($sformatf("out_code_%0d", val), out_code, exp_code);
        check($sformatf("done_idx_%0d", val), lut_idx, 5'd0);
      end
    end
    for (int h = 0; h < hold; h++) begin
      if (h == 0) begin
        in_valid = 1'b1;
        in_lin   = 11'd5;
      end
      @(negedge clk);
      check("hold_valid", out_valid, 1'b1);
      check("hold_code", out_code, exp_code);
      check("hold_ready", in_ready, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check($sformatf("release_valid_%0d", val), out_valid, 1'b0);
    check($sformatf("release_ready_%0d", val), in_ready, 1'b1);
    check($sformatf("idle_idx_%0d", val), lut_idx, 5'd0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_lin    = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_code", out_code, 5'd0);
    check("rst_lut_idx", lut_idx, 5'd0);

    xact(11'd0,    5'd0,  5'd0,  1'b1, {5'd16, 5'd8,  5'd4,  5'd2,  5'd1},  0);
    xact(11'd2047, 5'd31, 5'd31, 1'b1, {5'd16, 5'd24, 5'd28, 5'd30, 5'd31}, 0);
    xact(11'd363,  5'd11, 5'd12, 1'b0, '0, 0);
    xact(11'd364,  5'd12, 5'd12, 1'b0, '0, 0);
    xact(11'd1000, 5'd21, 5'd21, 1'b0, '0, 0);
    xact(11'd48,   5'd0,  5'd1,  1'b0, '0, 0);
    xact(11'd1500, 5'd25, 5'd26, 1'b0, '0, 0);
    xact(11'd2037, 5'd30, 5'd31, 1'b0, '0, 0);
    xact(11'd2038, 5'd31, 5'd31, 1'b0, '0, 0);

    // Backpressure with a stray in_valid during DONE, then a fresh value.
    xact(11'd1000, 5'd21, 5'd21, 1'b0, '0, 10);
    xact(11'd363,  5'd11, 5'd12, 1'b0, '0, 0);

    // Reset during the third SEARCH cycle discards the value.
    in_valid = 1'b1;
    in_lin   = 11'd2047;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_ready", in_ready, 1'b1);
    check("midrst_idx", lut_idx, 5'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("midrst_no_valid", out_valid, 1'b0);
    end
    xact(11'd574, 5'd16, 5'd16, 1'b0, '0, 0);

    // Reset and in_valid together: nothing accepted.
    reset    = 1'b1;
    in_valid = 1'b1;
    in_lin   = 11'd2047;
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    check("rstvalid_ready", in_ready, 1'b1);
    check("rstvalid_idx", lut_idx, 5'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rstvalid_no_valid", out_valid, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
